// File: rtl/sms_cart_loader.sv
// sms_cart_loader: ioctl ROM download -> SDRAM writer with FIFO, 16KB bank padding and bank-mask derivation.
// Optional build macro CART_CHECKSUM_EN enables the cart_sum byte accumulator.
`default_nettype none

module sms_cart_loader #(
  parameter logic [7:0] ROM_INDEX  = 8'd1,
  parameter int         ADDR_W     = 22,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_busy,
  output logic [7:0]        cart_mask,
  output logic              rom_loaded,
  output logic              size_err,
  output logic [15:0]       cart_sum
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LVL = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PAD    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state;
  logic              dl_q;
  logic              fin_done;
  logic [25:0]       len;
  logic [25:0]       paddr;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic        dl_rise, dl_fall, start, in_range;
  logic        fifo_empty, fifo_full, push, pop;
  logic        pad_we, pad_acc;
  logic [25:0] addr_p1;
  logic [11:0] banks, banks_m1;
  logic [7:0]  m1, m2, mask_calc;

  assign dl_rise    = ioctl_download & ~dl_q & (ioctl_index == ROM_INDEX);
  assign dl_fall    = ~ioctl_download & dl_q;
  // A matching rising edge restarts the session from any state except LOAD.
  assign start      = dl_rise & (state != S_LOAD);
  assign in_range   = (ioctl_addr >> ADDR_W) == 25'd0;
  assign addr_p1    = {1'b0, ioctl_addr} + 26'd1;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign push       = (state == S_LOAD) & ioctl_wr & in_range & ~fifo_full;
  assign pop        = ~fifo_empty & ~mem_busy;
  assign pad_we     = (state == S_PAD) & fifo_empty;
  assign pad_acc    = pad_we & ~mem_busy;

  assign mem_we   = ~fifo_empty | pad_we;
  assign mem_addr = fifo_empty ? paddr[ADDR_W-1:0] : fifo_addr[rd_ptr];
  assign mem_din  = fifo_empty ? PAD_BYTE : fifo_data[rd_ptr];

  // Round the bank count up to a power of two by smearing (banks-1) rightwards.
  assign banks     = len[25:14] + {11'd0, |len[13:0]};
  assign banks_m1  = banks - 12'd1;
  assign m1        = banks_m1[7:0] | (banks_m1[7:0] >> 1);
  assign m2        = m1 | (m1 >> 2);
  assign mask_calc = (|banks_m1[11:8]) ? 8'hFF : (m2 | (m2 >> 4));

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ioctl_addr[ADDR_W-1:0];
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      fin_done   <= 1'b0;
      len        <= '0;
      paddr      <= '0;
      ioctl_wait <= 1'b0;
      cart_mask  <= 8'h00;
      rom_loaded <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      ioctl_wait <= (count_nxt >= WAIT_LVL);
      if (start) begin
        state      <= S_LOAD;
        len        <= '0;
        rom_loaded <= 1'b0;
        size_err   <= 1'b0;
        fin_done   <= 1'b0;
      end else begin
        case (state)
          S_LOAD: begin
            if (ioctl_wr) begin
              if (addr_p1 > len) len <= addr_p1;
              if (!in_range || fifo_full) size_err <= 1'b1;
            end
            if (dl_fall) begin
              if (len[13:0] != 14'd0) begin
                state      <= S_PAD;
                paddr      <= len;
                ioctl_wait <= 1'b1;
              end else if (len == 26'd0) begin
                size_err <= 1'b1;
                state    <= S_IDLE;
              end else begin
                state <= S_FINISH;
              end
            end
          end
          S_PAD: begin
            if (pad_acc) paddr <= paddr + 26'd1;
            if (pad_acc && paddr[13:0] == 14'h3FFF)
              state <= S_FINISH;
            else
              ioctl_wait <= 1'b1;
          end
          S_FINISH: begin
            if (fin_done) begin
              rom_loaded <= 1'b1;
              fin_done   <= 1'b0;
              state      <= S_IDLE;
            end else if (fifo_empty) begin
              cart_mask <= mask_calc;
              fin_done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  logic [15:0] sum_r;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      sum_r <= 16'h0000;
    else if (start)
      sum_r <= 16'h0000;
    else if (push)
      sum_r <= sum_r + {8'h00, ioctl_dout};
  end
  assign cart_sum = sum_r;
`else
  assign cart_sum = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sms_cart_loader.sv
// tb_sms_cart_loader: table-driven single-byte sessions plus directed backpressure, reset and error sequences.
`default_nettype none

module tb_sms_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, mem_busy;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, mem_we, rom_loaded, size_err;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din, cart_mask;
  logic [15:0] cart_sum;

  int checks   = 0;
  int failures = 0;
  logic [29:0] wlog [$];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [7:0]  mask;
    int          pad;
  } vec_t;
  vec_t vecs [10];

  sms_cart_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_busy(mem_busy),
    .cart_mask(cart_mask), .rom_loaded(rom_loaded), .size_err(size_err),
    .cart_sum(cart_sum)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every write the SDRAM side accepts at the coming edge.
  always @(negedge clk_sys)
    if (!reset && mem_we && !mem_busy) wlog.push_back({mem_addr, mem_din});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_loaded(input int budget);
    int n = 0;
    while (!rom_loaded && n < budget) begin
      tick();
      n++;
    end
    check("loaded", {31'd0, rom_loaded}, 32'd1);
  endtask

  // Count log entries from 'first' onward that are not PAD_BYTE at consecutive addresses.
  function automatic int pad_errors(input int first, input logic [21:0] a0);
    int bad = 0;
    for (int i = first; i < wlog.size(); i++) begin
      logic [21:0] ea;
      ea = a0 + 22'(i - first);
      if (wlog[i] !== {ea, 8'hFF}) bad++;
    end
    return bad;
  endfunction

  initial begin
    vecs[0] = '{25'h003FFF, 8'h11, 8'h00, 0};
    vecs[1] = '{25'h007FFF, 8'h22, 8'h01, 0};
    vecs[2] = '{25'h00BFFF, 8'h33, 8'h03, 0};
    vecs[3] = '{25'h00FFFF, 8'h44, 8'h03, 0};
    vecs[4] = '{25'h013FFF, 8'h55, 8'h07, 0};
    vecs[5] = '{25'h1FFFFF, 8'h66, 8'h7F, 0};
    vecs[6] = '{25'h203FFF, 8'h77, 8'hFF, 0};
    vecs[7] = '{25'h3FFFFF, 8'h88, 8'hFF, 0};
    vecs[8] = '{25'h003FF0, 8'h99, 8'h00, 15};
    vecs[9] = '{25'h009FFE, 8'hAA, 8'h03, 8193};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; mem_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_wait", {31'd0, ioctl_wait}, 0);
    check("rst_mask", {24'd0, cart_mask}, 0);
    check("rst_loaded", {31'd0, rom_loaded}, 0);
    check("rst_size_err", {31'd0, size_err}, 0);
    check("rst_sum", {16'd0, cart_sum}, 0);

    // One-cycle latency from ioctl_wr to mem_we on an empty FIFO.
    wlog.delete();
    start_dl(8'd1);
    send(25'h003FFF, 8'h5A);
    check("lat_we", {31'd0, mem_we}, 1);
    check("lat_addr", {10'd0, mem_addr}, 32'h3FFF);
    check("lat_din", {24'd0, mem_din}, 32'h5A);
    end_dl();
    wait_loaded(100);
    check("lat_mask", {24'd0, cart_mask}, 0);

    for (int v = 0; v < 10; v++) begin
      wlog.delete();
      start_dl(8'd1);
      send(vecs[v].addr, vecs[v].data);
      end_dl();
      wait_loaded(20000);
      check($sformatf("v%0d_mask", v), {24'd0, cart_mask}, {24'd0, vecs[v].mask});
      check($sformatf("v%0d_nwr", v), wlog.size(), 1 + vecs[v].pad);
      if (wlog.size() > 0)
        check($sformatf("v%0d_first", v), {2'd0, wlog[0]}, {2'd0, vecs[v].addr[21:0], vecs[v].data});
      check($sformatf("v%0d_pad", v), pad_errors(1, vecs[v].addr[21:0] + 22'd1), 0);
      check($sformatf("v%0d_err", v), {31'd0, size_err}, 0);
    end

    // Asynchronous reset while padding.
    wlog.delete();
    start_dl(8'd1);
    send(25'h004000, 8'h12);
    end_dl();
    for (int n = 0; n < 50 && wlog.size() < 4; n++) tick();
    check("rp_in_pad_wait", {31'd0, ioctl_wait}, 1);
    #2 reset = 1'b1;
    #1;
    check("rp_mem_we", {31'd0, mem_we}, 0);
    check("rp_loaded", {31'd0, rom_loaded}, 0);
    check("rp_mask", {24'd0, cart_mask}, 0);
    check("rp_wait", {31'd0, ioctl_wait}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Backpressure: FIFO fills, wait rises at count 3, overflow byte dropped.
    wlog.delete();
    mem_busy = 1'b1;
    start_dl(8'd1);
    send(25'd0, 8'hA0);
    send(25'd1, 8'hA1);
    check("bp_wait2", {31'd0, ioctl_wait}, 0);
    send(25'd2, 8'hA2);
    check("bp_wait3", {31'd0, ioctl_wait}, 1);
    send(25'd3, 8'hA3);
    send(25'd1, 8'hEE);
    check("bp_ovf_err", {31'd0, size_err}, 1);
    repeat (5) tick();
    check("bp_we_busy", {31'd0, mem_we}, 1);
    check("bp_head", {10'd0, mem_addr}, 0);
    check("bp_no_wr", wlog.size(), 0);
    mem_busy = 1'b0;
    repeat (6) tick();
    end_dl();
    wait_loaded(20000);
    check("bp_nwr", wlog.size(), 16384);
    for (int i = 0; i < 4; i++)
      if (wlog.size() > i)
        check($sformatf("bp_byte%0d", i), {2'd0, wlog[i]}, {2'd0, 22'(i), 8'(8'hA0 + i)});
    check("bp_pad", pad_errors(4, 22'd4), 0);
    check("bp_err_held", {31'd0, size_err}, 1);

    // Three-byte file: checksum and single-bank pad.
    wlog.delete();
    start_dl(8'd1);
    send(25'd0, 8'h01);
    send(25'd1, 8'h02);
    send(25'd2, 8'hFF);
    end_dl();
    wait_loaded(20000);
`ifdef CART_CHECKSUM_EN
    check("cs_sum", {16'd0, cart_sum}, 32'h0102);
`else
    check("cs_sum", {16'd0, cart_sum}, 32'h0000);
`endif
    check("cs_mask", {24'd0, cart_mask}, 0);
    check("cs_nwr", wlog.size(), 16384);
    check("cs_pad", pad_errors(3, 22'd3), 0);

    // rom_loaded follows the cart_mask update by exactly one cycle.
    start_dl(8'd1);
    send(25'h007FFF, 8'h3C);
    end_dl();
    for (int n = 0; n < 100 && cart_mask != 8'h01; n++) tick();
    check("lag_mask", {24'd0, cart_mask}, 32'h01);
    check("lag_loaded0", {31'd0, rom_loaded}, 0);
    tick();
    check("lag_loaded1", {31'd0, rom_loaded}, 1);

    // Non-matching index is ignored.
    wlog.delete();
    start_dl(8'd2);
    send(25'd0, 8'h77);
    send(25'd1, 8'h78);
    end_dl();
    repeat (30) tick();
    check("idx2_nwr", wlog.size(), 0);
    check("idx2_loaded", {31'd0, rom_loaded}, 1);
    check("idx2_mask", {24'd0, cart_mask}, 32'h01);

    // Empty file.
    wlog.delete();
    start_dl(8'd1);
    end_dl();
    repeat (10) tick();
    check("empty_err", {31'd0, size_err}, 1);
    check("empty_loaded", {31'd0, rom_loaded}, 0);
    check("empty_nwr", wlog.size(), 0);
    check("empty_mask", {24'd0, cart_mask}, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
